// File: rtl/reg_bank.sv
// Decode-stage operand fetch: 32x8 register file with one synchronous write port
// and forwarding/immediate muxes driving the combinational operands A and B.
module reg_bank (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins,
  input  logic [4:0]  RW_dm,
  input  logic [7:0]  mux_ans_dm,
  input  logic [7:0]  ans_ex,
  input  logic [7:0]  ans_wb,
  input  logic [7:0]  imm,
  input  logic [1:0]  mux_sel_A,
  input  logic [1:0]  mux_sel_B,
  input  logic        imm_sel,
  output logic [7:0]  A,
  output logic [7:0]  B
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_EX = 2'd1;
  localparam logic [1:0] SEL_DM = 2'd2;
  localparam logic [1:0] SEL_WB = 2'd3;

  logic [DATA_W-1:0] regs [NREGS];
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] fwd_b;
  logic              unused_ins;

  assign ra = ins[14:10];
  assign rb = ins[9:5];
  // Opcode and destination fields belong to other pipeline stages.
  assign unused_ins = ^{ins[19:15], ins[4:0]};

  // Write port: no enable, upstream parks RW_dm on a harmless register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      regs[RW_dm] <= mux_ans_dm;
    end
  end

  // Asynchronous reads, no internal bypass of the in-flight write.
  assign rf_a = regs[ra];
  assign rf_b = regs[rb];

  always_comb begin
    A = rf_a;
    unique case (mux_sel_A)
      SEL_RF: A = rf_a;
      SEL_EX: A = ans_ex;
      SEL_DM: A = mux_ans_dm;
      SEL_WB: A = ans_wb;
      default: A = rf_a;
    endcase
  end

  always_comb begin
    fwd_b = rf_b;
    unique case (mux_sel_B)
      SEL_RF: fwd_b = rf_b;
      SEL_EX: fwd_b = ans_ex;
      SEL_DM: fwd_b = mux_ans_dm;
      SEL_WB: fwd_b = ans_wb;
      default: fwd_b = rf_b;
    endcase
  end

  assign B = imm_sel ? imm : fwd_b;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: expected operands are queued when stimulus is
// driven and compared when A/B are sampled between clock edges.
module tb_reg_bank;

  logic        clk;
  logic        reset;
  logic [19:0] ins;
  logic [4:0]  RW_dm;
  logic [7:0]  mux_ans_dm;
  logic [7:0]  ans_ex;
  logic [7:0]  ans_wb;
  logic [7:0]  imm;
  logic [1:0]  mux_sel_A;
  logic [1:0]  mux_sel_B;
  logic        imm_sel;
  logic [7:0]  A;
  logic [7:0]  B;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mdl [32];
  logic [15:0] exp_q [$];
  string       tag_q [$];

  reg_bank dut (
    .clk(clk), .reset(reset), .ins(ins), .RW_dm(RW_dm), .mux_ans_dm(mux_ans_dm),
    .ans_ex(ans_ex), .ans_wb(ans_wb), .imm(imm), .mux_sel_A(mux_sel_A),
    .mux_sel_B(mux_sel_B), .imm_sel(imm_sel), .A(A), .B(B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    exp_q.push_back({ea, eb});
    tag_q.push_back(tag);
  endtask

  // Sample 1ns after the drive, well clear of the rising edge.
  task automatic pop_check();
    logic [15:0] e;
    string t;
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_A"}, A, e[15:8]);
      check({t, "_B"}, B, e[7:0]);
    end
  endtask

  // Advance one cycle; the model takes the write on the rising edge.
  task automatic step();
    @(posedge clk);
    if (reset) mdl[RW_dm] = mux_ans_dm;
    @(negedge clk);
  endtask

  function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] rf);
    if (s == 2'd1) return ans_ex;
    if (s == 2'd2) return mux_ans_dm;
    if (s == 2'd3) return ans_wb;
    return rf;
  endfunction

  function automatic logic [7:0] model_a();
    logic [4:0] r;
    r = ins[14:10];
    return pick(mux_sel_A, (reset ? mdl[r] : 8'h00));
  endfunction

  function automatic logic [7:0] model_b();
    logic [4:0] r;
    r = ins[9:5];
    if (imm_sel) return imm;
    return pick(mux_sel_B, (reset ? mdl[r] : 8'h00));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    reset = 1'b0; ins = 20'h014C5; RW_dm = 5'd31; mux_ans_dm = 8'h00;
    ans_ex = 8'h00; ans_wb = 8'h00; imm = 8'h00;
    mux_sel_A = 2'd0; mux_sel_B = 2'd0; imm_sel = 1'b0;
    #2;
    push_exp("reset_state", 8'h00, 8'h00); pop_check();
    @(negedge clk);
    reset = 1'b1;

    // Directed write/read through A then B.
    RW_dm = 5'd5; mux_ans_dm = 8'h02; step();
    push_exp("wr_a", 8'h02, 8'h00); pop_check();
    RW_dm = 5'd6; mux_ans_dm = 8'h05; step();
    push_exp("wr_b", 8'h02, 8'h05); pop_check();
    RW_dm = 5'd7; step();
    push_exp("wr_r7", 8'h02, 8'h05); pop_check();

    // Async reset pulse between edges clears everything.
    #1 reset = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    push_exp("rst_during", 8'h00, 8'h00); pop_check();
    reset = 1'b1;
    push_exp("rst_after", 8'h00, 8'h00); pop_check();
    step();

    RW_dm = 5'd5; mux_ans_dm = 8'h02; step();
    RW_dm = 5'd6; mux_ans_dm = 8'h05; step();
    RW_dm = 5'd7; step();
    push_exp("rewrite", 8'h02, 8'h05); pop_check();
    step();

    // Forwarding selects take effect with no clock.
    ans_ex = 8'h01; mux_ans_dm = 8'h05; ans_wb = 8'h03;
    mux_sel_A = 2'd1; push_exp("fwd_a_ex", 8'h01, 8'h05); pop_check();
    mux_sel_A = 2'd2; push_exp("fwd_a_dm", 8'h05, 8'h05); pop_check();
    mux_sel_B = 2'd3; push_exp("fwd_b_wb", 8'h05, 8'h03); pop_check();
    step();
    imm = 8'h04; imm_sel = 1'b1;
    push_exp("imm_on", 8'h05, 8'h04); pop_check();
    mux_sel_B = 2'd1; push_exp("imm_over_sel", 8'h05, 8'h04); pop_check();
    mux_sel_B = 2'd3; imm_sel = 1'b0;
    push_exp("imm_off", 8'h05, 8'h03); pop_check();
    step();

    // Same-cycle read of the register being written sees the old value.
    mux_sel_A = 2'd0; mux_sel_B = 2'd0; RW_dm = 5'd5; mux_ans_dm = 8'hAA;
    push_exp("rw_before", 8'h02, 8'h05); pop_check();
    step();
    push_exp("rw_after", 8'hAA, 8'h05); pop_check();

    // Fill every register, including r0, then read all back on both ports.
    for (int i = 0; i < 32; i++) begin
      RW_dm = 5'(i); mux_ans_dm = 8'(i * 7 + 3); step();
    end
    RW_dm = 5'd31; mux_ans_dm = 8'(31 * 7 + 3);
    for (int i = 0; i < 32; i++) begin
      ins = {5'd0, 5'(i), 5'(31 - i), 5'd0};
      push_exp("sweep", 8'(i * 7 + 3), 8'((31 - i) * 7 + 3)); pop_check();
      step();
    end

    // Random traffic checked against the model, sampled before each edge.
    for (int n = 0; n < 60; n++) begin
      ins = 20'($urandom); RW_dm = 5'($urandom); mux_ans_dm = 8'($urandom);
      ans_ex = 8'($urandom); ans_wb = 8'($urandom); imm = 8'($urandom);
      mux_sel_A = 2'($urandom); mux_sel_B = 2'($urandom); imm_sel = 1'($urandom_range(0, 3) == 0);
      push_exp("rand", model_a(), model_b()); pop_check();
      step();
    end

    // Mid-operation reset held across edges: no writes, all registers read zero.
    mux_sel_A = 2'd0; mux_sel_B = 2'd0; imm_sel = 1'b0;
    #1 reset = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    for (int i = 0; i < 32; i++) begin
      ins = {5'd0, 5'(i), 5'(i ^ 5), 5'd0}; RW_dm = 5'(i); mux_ans_dm = 8'hFF;
      push_exp("rst_hold", 8'h00, 8'h00); pop_check();
      step();
    end
    reset = 1'b1;
    ins = {5'd0, 5'd9, 5'd10, 5'd0}; RW_dm = 5'd9; mux_ans_dm = 8'h5C;
    push_exp("post_rst_pre", 8'h00, 8'h00); pop_check();
    step();
    push_exp("post_rst_wr", 8'h5C, 8'h00); pop_check();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
